// File: rtl/fust_issue_sched_pkg.sv
// Shared types for the FU status table issue scheduler.
package fust_issue_sched_pkg;

    localparam int unsigned NUM_FU_DEF  = 5;
    localparam int unsigned NUM_SRC_DEF = 3;
    localparam int unsigned TAG_W_DEF   = $clog2(NUM_FU_DEF);

    typedef enum logic [1:0] {
        FUST_EMPTY = 2'd0,
        FUST_WAIT  = 2'd1,
        FUST_RDY   = 2'd2,
        FUST_EX    = 2'd3
    } fust_state_e;

    typedef logic [TAG_W_DEF-1:0] fu_tag_t;

endpackage

// File: rtl/fust_issue_sched_age.sv
// Age matrix: age_q[r][c] means slot r is older than slot c. Picks the oldest eligible slot.
module fust_issue_sched_age #(
    parameter int unsigned NUM_FU = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [NUM_FU-1:0] set,
    input  logic [NUM_FU-1:0] clr,
    input  logic [NUM_FU-1:0] busy,
    input  logic [NUM_FU-1:0] elig,
    output logic [NUM_FU-1:0] older_elig,
    output logic [NUM_FU-1:0] pick
);

    logic [NUM_FU-1:0] age_q [NUM_FU];
    logic [NUM_FU-1:0] age_d [NUM_FU];

    always_comb begin
        for (int r = 0; r < NUM_FU; r++) begin
            for (int c = 0; c < NUM_FU; c++) begin
                age_d[r][c] = age_q[r][c];
                if (r == c || clr[r] || clr[c] || set[r]) begin
                    age_d[r][c] = 1'b0;
                end else if (set[c]) begin
                    // Every slot already in flight is older than the new arrival.
                    age_d[r][c] = busy[r];
                end
            end
        end
    end

    always_comb begin
        older_elig = '0;
        for (int c = 0; c < NUM_FU; c++) begin
            for (int r = 0; r < NUM_FU; r++) begin
                older_elig[c] = older_elig[c] | (elig[r] & age_q[r][c]);
            end
        end
        pick = elig & ~older_elig;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int r = 0; r < NUM_FU; r++) age_q[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_FU; r++) age_q[r] <= age_d[r];
        end
    end

endmodule

// File: rtl/fust_issue_sched.sv
// Oldest-ready-first issue scheduler over one single-entry slot per functional unit.
module fust_issue_sched
    import fust_issue_sched_pkg::*;
#(
    parameter int unsigned NUM_FU  = NUM_FU_DEF,
    parameter int unsigned NUM_SRC = NUM_SRC_DEF,
    parameter int unsigned TAG_W   = $clog2(NUM_FU)
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     alloc_valid,
    input  logic [TAG_W-1:0]         alloc_fu,
    input  logic                     alloc_spec,
    input  logic [NUM_SRC-1:0]       alloc_pend,
    input  logic [NUM_SRC*TAG_W-1:0] alloc_tag,
    input  logic                     wb_valid,
    input  logic [TAG_W-1:0]         wb_fu,
    input  logic [NUM_FU-1:0]        fu_done,
    input  logic                     branch_miss,
    input  logic                     branch_ok,
    input  logic                     issue_ready,
    output logic                     issue_valid,
    output logic [TAG_W-1:0]         issue_fu,
    output logic [NUM_FU*2-1:0]      slot_state,
    output logic [NUM_FU-1:0]        slot_busy,
    output logic                     alloc_err
);

    fust_state_e              state_q [NUM_FU];
    fust_state_e              state_d [NUM_FU];
    logic [NUM_SRC-1:0]       pend_q  [NUM_FU];
    logic [NUM_SRC-1:0]       pend_d  [NUM_FU];
    logic [NUM_SRC*TAG_W-1:0] tag_q   [NUM_FU];
    logic [NUM_SRC*TAG_W-1:0] tag_d   [NUM_FU];
    logic [NUM_SRC-1:0]       wake    [NUM_FU];
    logic [NUM_FU-1:0]        spec_q, spec_d;
    logic [NUM_FU-1:0]        elig, pick, older_elig, age_set, age_clr;
    logic [NUM_SRC-1:0]       alloc_pend_byp;
    logic                     err_d, err_q, drop_spec;

    assign drop_spec = branch_miss & alloc_spec;

    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            alloc_pend_byp[k] = alloc_pend[k] &
                                !(wb_valid && alloc_tag[k*TAG_W +: TAG_W] == wb_fu);
        end
        for (int i = 0; i < NUM_FU; i++) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                wake[i][k] = wb_valid && tag_q[i][k*TAG_W +: TAG_W] == wb_fu;
            end
            elig[i]      = (state_q[i] == FUST_RDY) && !(branch_miss && spec_q[i]);
            slot_busy[i] = (state_q[i] != FUST_EMPTY);
            slot_state[2*i +: 2] = state_q[i];
        end
    end

    always_comb begin
        issue_valid = |pick;
        issue_fu    = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (pick[i]) issue_fu = TAG_W'(i);
        end
    end

    always_comb begin
        err_d = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            logic hit, done, squash, free;
            hit    = alloc_valid && (alloc_fu == TAG_W'(i));
            done   = (state_q[i] == FUST_EX) && fu_done[i];
            squash = branch_miss && spec_q[i];
            free   = (state_q[i] == FUST_EMPTY) || done;

            state_d[i] = state_q[i];
            pend_d[i]  = pend_q[i];
            tag_d[i]   = tag_q[i];
            spec_d[i]  = spec_q[i] & ~(branch_ok & ~branch_miss);

            unique case (state_q[i])
                FUST_WAIT: begin
                    if (squash) begin
                        state_d[i] = FUST_EMPTY;
                    end else begin
                        pend_d[i]  = pend_q[i] & ~wake[i];
                        state_d[i] = (pend_d[i] == '0) ? FUST_RDY : FUST_WAIT;
                    end
                end
                FUST_RDY: begin
                    if (squash) state_d[i] = FUST_EMPTY;
                    else if (pick[i] && issue_ready) state_d[i] = FUST_EX;
                end
                FUST_EX: begin
                    if (fu_done[i]) state_d[i] = FUST_EMPTY;
                end
                default: ;
            endcase

            if (state_d[i] == FUST_EMPTY) begin
                pend_d[i] = '0;
                tag_d[i]  = '0;
                spec_d[i] = 1'b0;
            end

            age_set[i] = hit && free && !drop_spec;
            if (age_set[i]) begin
                state_d[i] = (alloc_pend_byp == '0) ? FUST_RDY : FUST_WAIT;
                pend_d[i]  = alloc_pend_byp;
                tag_d[i]   = alloc_tag;
                spec_d[i]  = alloc_spec & ~branch_ok;
            end
            if (hit && !free && !drop_spec) err_d = 1'b1;

            age_clr[i] = (state_q[i] != FUST_EMPTY) && (state_d[i] == FUST_EMPTY);
        end
    end

    fust_issue_sched_age #(
        .NUM_FU (NUM_FU)
    ) u_age (
        .CLK        (CLK),
        .nRST       (nRST),
        .set        (age_set),
        .clr        (age_clr),
        .busy       (slot_busy),
        .elig       (elig),
        .older_elig (older_elig),
        .pick       (pick)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_FU; i++) begin
                state_q[i] <= FUST_EMPTY;
                pend_q[i]  <= '0;
                tag_q[i]   <= '0;
            end
            spec_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                state_q[i] <= state_d[i];
                pend_q[i]  <= pend_d[i];
                tag_q[i]   <= tag_d[i];
            end
            spec_q <= spec_d;
            err_q  <= err_d;
        end
    end

    assign alloc_err = err_q;

endmodule

// File: tb/tb_fust_issue_sched.sv
// Directed bench for fust_issue_sched: grant-order scoreboard plus direct state checks.
module tb_fust_issue_sched;
    import fust_issue_sched_pkg::*;

    localparam int NF = 5;
    localparam int NS = 3;
    localparam int TW = 3;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              alloc_valid = 1'b0;
    logic [TW-1:0]     alloc_fu = '0;
    logic              alloc_spec = 1'b0;
    logic [NS-1:0]     alloc_pend = '0;
    logic [NS*TW-1:0]  alloc_tag = '0;
    logic              wb_valid = 1'b0;
    logic [TW-1:0]     wb_fu = '0;
    logic [NF-1:0]     fu_done = '0;
    logic              branch_miss = 1'b0;
    logic              branch_ok = 1'b0;
    logic              issue_ready = 1'b0;
    logic              issue_valid;
    logic [TW-1:0]     issue_fu;
    logic [NF*2-1:0]   slot_state;
    logic [NF-1:0]     slot_busy;
    logic              alloc_err;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    localparam int S_EMPTY = 0, S_WAIT = 1, S_RDY = 2, S_EX = 3;

    fust_issue_sched dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .alloc_valid (alloc_valid),
        .alloc_fu    (alloc_fu),
        .alloc_spec  (alloc_spec),
        .alloc_pend  (alloc_pend),
        .alloc_tag   (alloc_tag),
        .wb_valid    (wb_valid),
        .wb_fu       (wb_fu),
        .fu_done     (fu_done),
        .branch_miss (branch_miss),
        .branch_ok   (branch_ok),
        .issue_ready (issue_ready),
        .issue_valid (issue_valid),
        .issue_fu    (issue_fu),
        .slot_state  (slot_state),
        .slot_busy   (slot_busy),
        .alloc_err   (alloc_err)
    );

    always #5 CLK = ~CLK;

    function automatic int sst(int i);
        return int'(slot_state[2*i +: 2]);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic alloc(int fu, bit spec, logic [NS-1:0] pend, logic [NS*TW-1:0] tag);
        alloc_valid = 1'b1;
        alloc_fu    = TW'(fu);
        alloc_spec  = spec;
        alloc_pend  = pend;
        alloc_tag   = tag;
        step();
        alloc_valid = 1'b0;
        alloc_spec  = 1'b0;
        alloc_pend  = '0;
        alloc_tag   = '0;
    endtask

    task automatic grant(int fu);
        exp_q.push_back(fu);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
    endtask

    task automatic done(logic [NF-1:0] m);
        fu_done = m;
        step();
        fu_done = '0;
    endtask

    task automatic wb(int fu);
        wb_valid = 1'b1;
        wb_fu    = TW'(fu);
        step();
        wb_valid = 1'b0;
    endtask

    // Grant monitor: every accepted grant must match the next queued expectation.
    initial begin
        int e;
        forever begin
            @(negedge CLK);
            if (nRST && issue_valid && issue_ready) begin
                if (exp_q.size() == 0) begin
                    check("grant_unexpected", int'(issue_fu), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_order", int'(issue_fu), e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: reset values, simple alloc/issue/done
        #12;
        check("rst_busy", int'(slot_busy), 0);
        check("rst_state", int'(slot_state), 0);
        check("rst_issue_valid", int'(issue_valid), 0);
        check("rst_alloc_err", int'(alloc_err), 0);
        #11 nRST = 1'b1;
        step();
        alloc(0, 0, 3'b000, '0);
        check("t1_rdy", sst(0), S_RDY);
        check("t1_issue_valid", int'(issue_valid), 1);
        check("t1_issue_fu", int'(issue_fu), 0);
        grant(0);
        check("t1_ex", sst(0), S_EX);
        done(5'b00001);
        check("t1_empty", sst(0), S_EMPTY);

        // Test 2: wakeup and same-cycle bypass
        alloc(1, 0, 3'b001, 9'd0);
        check("t2_wait", sst(1), S_WAIT);
        check("t2_no_issue", int'(issue_valid), 0);
        wb(0);
        check("t2_woken", sst(1), S_RDY);
        grant(1);
        done(5'b00010);
        wb_valid = 1'b1;
        wb_fu    = 3'd3;
        alloc(2, 0, 3'b110, 9'b011_011_000);
        wb_valid = 1'b0;
        check("t2_bypass_rdy", sst(2), S_RDY);
        wb_valid = 1'b1;
        wb_fu    = 3'd2;
        alloc(3, 0, 3'b001, 9'd1);
        wb_valid = 1'b0;
        check("t2_tag_mismatch_wait", sst(3), S_WAIT);
        grant(2);
        done(5'b00100);
        wb(1);
        check("t2_slot3_rdy", sst(3), S_RDY);
        grant(3);
        done(5'b01000);
        check("t2_all_empty", int'(slot_busy), 0);

        // Test 3: age order 4,2,0 and re-offer while stalled
        alloc(4, 0, 3'b000, '0);
        alloc(2, 0, 3'b000, '0);
        alloc(0, 0, 3'b000, '0);
        for (int c = 0; c < 3; c++) begin
            check("t3_reoffer_valid", int'(issue_valid), 1);
            check("t3_reoffer_fu", int'(issue_fu), 4);
            step();
        end
        exp_q.push_back(4);
        exp_q.push_back(2);
        exp_q.push_back(0);
        issue_ready = 1'b1;
        repeat (3) step();
        issue_ready = 1'b0;
        check("t3_all_ex", int'(slot_state), (S_EX << 8) | (S_EX << 4) | S_EX);
        done(5'b10101);
        check("t3_all_empty", int'(slot_busy), 0);

        // Test 4: branch miss squashes spec WAIT/RDY, leaves EX and non-spec
        alloc(3, 1, 3'b000, '0);
        grant(3);
        alloc(1, 1, 3'b000, '0);
        alloc(4, 0, 3'b001, 9'd0);
        branch_miss = 1'b1;
        issue_ready = 1'b1;
        #1;
        check("t4_no_grant_on_miss", int'(issue_valid), 0);
        step();
        branch_miss = 1'b0;
        issue_ready = 1'b0;
        check("t4_slot1_empty", sst(1), S_EMPTY);
        check("t4_slot3_ex", sst(3), S_EX);
        check("t4_slot4_wait", sst(4), S_WAIT);
        done(5'b01000);
        wb(0);
        check("t4_slot4_rdy", sst(4), S_RDY);
        grant(4);
        done(5'b10000);
        // branch_ok clears a same-cycle spec alloc, so a later miss keeps it
        branch_ok = 1'b1;
        alloc(1, 1, 3'b000, '0);
        branch_ok   = 1'b0;
        branch_miss = 1'b1;
        step();
        branch_miss = 1'b0;
        check("t4_ok_survives_miss", sst(1), S_RDY);
        grant(1);
        done(5'b00010);
        // spec alloc during a miss is dropped silently
        branch_miss = 1'b1;
        alloc(0, 1, 3'b000, '0);
        branch_miss = 1'b0;
        check("t4_spec_alloc_dropped", sst(0), S_EMPTY);
        check("t4_drop_no_err", int'(alloc_err), 0);

        // Test 5: alloc to busy slot flags an error; alloc with done is accepted
        alloc(2, 0, 3'b000, '0);
        alloc(2, 0, 3'b001, 9'd0);
        check("t5_err_pulse", int'(alloc_err), 1);
        check("t5_state_kept", sst(2), S_RDY);
        step();
        check("t5_err_one_cycle", int'(alloc_err), 0);
        grant(2);
        fu_done = 5'b00100;
        alloc(2, 0, 3'b001, 9'd0);
        fu_done = '0;
        check("t5_done_alloc_no_err", int'(alloc_err), 0);
        check("t5_done_alloc_wait", sst(2), S_WAIT);

        // Test 6: async reset with every slot busy
        alloc(0, 0, 3'b001, 9'd0);
        alloc(1, 0, 3'b001, 9'd0);
        alloc(3, 0, 3'b001, 9'd0);
        alloc(4, 0, 3'b000, '0);
        check("t6_all_busy", int'(slot_busy), 5'b11111);
        check("t6_issue_before_rst", int'(issue_valid), 1);
        alloc(0, 0, 3'b000, '0);
        check("t6_err_before_rst", int'(alloc_err), 1);
        #2 nRST = 1'b0;
        #1;
        check("t6_rst_busy", int'(slot_busy), 0);
        check("t6_rst_state", int'(slot_state), 0);
        check("t6_rst_issue_valid", int'(issue_valid), 0);
        check("t6_rst_issue_fu", int'(issue_fu), 0);
        check("t6_rst_alloc_err", int'(alloc_err), 0);
        step();
        #2 nRST = 1'b1;
        step();
        alloc(0, 0, 3'b000, '0);
        check("t6_rdy", sst(0), S_RDY);
        check("t6_issue_fu", int'(issue_fu), 0);
        grant(0);
        check("t6_ex", sst(0), S_EX);
        done(5'b00001);
        check("t6_empty", int'(slot_busy), 0);

        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
